// File: rtl/m_memarb.sv
// m_memarb: single-port memory arbiter shared by fetch, data and loader.
// Loader mode quiesces the pipeline; a one-cycle DRAIN follows each load.
module m_memarb #(
  parameter int AW         = 11,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          w_clk,
  input  logic          w_rst,
  input  logic          w_ireq,
  input  logic [AW-1:0] w_iaddr,
  output logic          w_igrant,
  output logic          r_ivalid,
  output logic [DW-1:0] w_idata,
  input  logic          w_dreq,
  input  logic          w_dwe,
  input  logic [AW-1:0] w_daddr,
  input  logic [DW-1:0] w_ddin,
  output logic          w_dgrant,
  output logic          r_dvalid,
  output logic [DW-1:0] w_ddata,
  input  logic          w_lreq,
  input  logic          w_lwe,
  input  logic [AW-1:0] w_laddr,
  input  logic [DW-1:0] w_ldin,
  output logic          w_lgrant,
  output logic          r_lvalid,
  output logic [DW-1:0] w_ldata,
  output logic [AW-1:0] w_maddr,
  output logic          w_mwe,
  output logic [DW-1:0] w_mdin,
  input  logic [DW-1:0] w_mdout,
  output logic          w_ifstall,
  output logic [1:0]    r_mode
);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_I    = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;
  localparam logic [1:0] OWN_L    = 2'd3;

  localparam logic [2:0] SMAX = 3'(STARVE_MAX);

  logic [1:0] mode_q, mode_d;
  logic [2:0] starve_q, starve_d;
  logic [1:0] own_q, own_d;
  logic       fetch_urgent;

  assign fetch_urgent = (starve_q == SMAX);

  always_comb begin
    w_igrant = 1'b0;
    w_dgrant = 1'b0;
    w_lgrant = 1'b0;
    if (mode_q == RUN) begin
      if (w_lreq)
        w_lgrant = 1'b1;
      else if (w_ireq && (fetch_urgent || !w_dreq))
        w_igrant = 1'b1;
      else if (w_dreq)
        w_dgrant = 1'b1;
    end else if (mode_q == LOAD) begin
      w_lgrant = w_lreq;
    end
  end

  always_comb begin
    mode_d = mode_q;
    unique case (mode_q)
      RUN:     if (w_lreq) mode_d = LOAD;
      LOAD:    if (!w_lreq) mode_d = DRAIN;
      DRAIN:   mode_d = w_lreq ? LOAD : RUN;
      default: mode_d = RUN;
    endcase
  end

  // Starvation only accrues while the arbiter is actually arbitrating.
  always_comb begin
    starve_d = starve_q;
    if (mode_q == RUN) begin
      if (w_ireq && !w_igrant)
        starve_d = (starve_q >= SMAX) ? SMAX
                                      : starve_q + 3'd1;
      else
        starve_d = '0;
    end
  end

  always_comb begin
    w_maddr = '0;
    w_mwe   = 1'b0;
    w_mdin  = '0;
    own_d   = OWN_NONE;
    unique case (1'b1)
      w_lgrant: begin
        w_maddr = w_laddr;
        w_mwe   = w_lwe;
        w_mdin  = w_ldin;
        own_d   = w_lwe ? OWN_NONE : OWN_L;
      end
      w_dgrant: begin
        w_maddr = w_daddr;
        w_mwe   = w_dwe;
        w_mdin  = w_ddin;
        own_d   = w_dwe ? OWN_NONE : OWN_D;
      end
      w_igrant: begin
        w_maddr = w_iaddr;
        own_d   = OWN_I;
      end
      default: ;
    endcase
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      mode_q   <= RUN;
      starve_q <= '0;
      own_q    <= OWN_NONE;
    end else begin
      mode_q   <= mode_d;
      starve_q <= starve_d;
      own_q    <= own_d;
    end
  end

  assign r_ivalid  = (own_q == OWN_I);
  assign r_dvalid  = (own_q == OWN_D);
  assign r_lvalid  = (own_q == OWN_L);
  assign w_idata   = r_ivalid ? w_mdout : '0;
  assign w_ddata   = r_dvalid ? w_mdout : '0;
  assign w_ldata   = r_lvalid ? w_mdout : '0;
  assign w_ifstall = w_ireq & ~w_igrant;
  assign r_mode    = mode_q;

endmodule

// File: tb/tb_m_memarb.sv
// tb_m_memarb: directed scenarios plus randomized traffic against a
// behavioural arbitration/memory model for m_memarb.
module tb_m_memarb;

  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        w_rst;
  logic        w_ireq, w_dreq, w_dwe, w_lreq, w_lwe;
  logic [10:0] w_iaddr, w_daddr, w_laddr;
  logic [31:0] w_ddin, w_ldin;
  logic        w_igrant, w_dgrant, w_lgrant;
  logic        r_ivalid, r_dvalid, r_lvalid;
  logic [31:0] w_idata, w_ddata, w_ldata;
  logic [10:0] w_maddr;
  logic        w_mwe;
  logic [31:0] w_mdin, w_mdout;
  logic        w_ifstall;
  logic [1:0]  r_mode;

  int vec = 0;
  int err = 0;

  logic [31:0] mem    [2048];
  logic [31:0] golden [2048];

  int          m_mode, m_starve, m_pend;
  logic [31:0] m_pdata;

  m_memarb #(.AW(11), .DW(32), .STARVE_MAX(SMAX)) dut (
    .w_clk(clk), .w_rst(w_rst),
    .w_ireq(w_ireq), .w_iaddr(w_iaddr),
    .w_igrant(w_igrant), .r_ivalid(r_ivalid),
    .w_idata(w_idata),
    .w_dreq(w_dreq), .w_dwe(w_dwe),
    .w_daddr(w_daddr), .w_ddin(w_ddin),
    .w_dgrant(w_dgrant), .r_dvalid(r_dvalid),
    .w_ddata(w_ddata),
    .w_lreq(w_lreq), .w_lwe(w_lwe),
    .w_laddr(w_laddr), .w_ldin(w_ldin),
    .w_lgrant(w_lgrant), .r_lvalid(r_lvalid),
    .w_ldata(w_ldata),
    .w_maddr(w_maddr), .w_mwe(w_mwe),
    .w_mdin(w_mdin), .w_mdout(w_mdout),
    .w_ifstall(w_ifstall), .r_mode(r_mode)
  );

  initial forever #5 clk = ~clk;

  // 2048x32 synchronous-read memory
  always @(posedge clk) begin
    if (w_mwe) mem[w_maddr] <= w_mdin;
    w_mdout <= mem[w_maddr];
  end

  initial begin
    for (int i = 0; i < 2048; i++) begin
      mem[i]    = 32'hA000_0000 | 32'(i * 7);
      golden[i] = 32'hA000_0000 | 32'(i * 7);
    end
  end

  task automatic idle();
    w_ireq = 0; w_iaddr = '0;
    w_dreq = 0; w_dwe = 0; w_daddr = '0; w_ddin = '0;
    w_lreq = 0; w_lwe = 0; w_laddr = '0; w_ldin = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    w_rst = 1;
    next_cycle();
    next_cycle();
    w_ireq = 1; w_iaddr = 11'd3;
    @(negedge clk);
    vec++;
    if (w_igrant !== 1'b1) begin
      err++;
      $display("FAIL rst_grant: got %b want 1", w_igrant);
    end
    next_cycle();
    w_rst = 0;
    idle();
    @(negedge clk);
    vec++;
    if (r_mode !== 2'd0 || dut.starve_q !== 3'd0) begin
      err++;
      $display("FAIL rst_state: mode %0d starve %0d want 0 0",
               r_mode, dut.starve_q);
    end
    vec++;
    if ({r_ivalid, r_dvalid, r_lvalid} !== 3'b000 ||
        {w_idata, w_ddata, w_ldata} !== 96'd0) begin
      err++;
      $display("FAIL rst_valid: got %b want 000",
               {r_ivalid, r_dvalid, r_lvalid});
    end
    vec++;
    if ({w_igrant, w_dgrant, w_lgrant, w_mwe} !== 4'b0 ||
        w_maddr !== 11'd0 || w_ifstall !== 1'b0) begin
      err++;
      $display("FAIL rst_idle: grants %b maddr %h want 0",
               {w_igrant, w_dgrant, w_lgrant}, w_maddr);
    end
  endtask

  task automatic test_fetch_only();
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      idle();
      if (i < 3) begin
        w_ireq = 1; w_iaddr = 11'(i);
      end
      @(negedge clk);
      vec++;
      if (w_igrant !== 1'(i < 3) || w_mwe !== 1'b0) begin
        err++;
        $display("FAIL fetch_grant[%0d]: got %b want %b",
                 i, w_igrant, i < 3);
      end
      if (i > 0) begin
        vec++;
        if (r_ivalid !== 1'b1 || w_idata !== golden[i-1]) begin
          err++;
          $display("FAIL fetch_data[%0d]: got %b/%h want 1/%h",
                   i, r_ivalid, w_idata, golden[i-1]);
        end
      end
    end
  endtask

  task automatic test_contention();
    for (int k = 0; k < 11; k++) begin
      next_cycle();
      idle();
      if (k < 10) begin
        w_ireq = 1; w_iaddr = 11'h30;
        w_dreq = 1; w_daddr = 11'h20;
      end
      @(negedge clk);
      if (k < 10) begin
        vec++;
        if (w_igrant !== 1'(k % 5 == 4) ||
            w_dgrant !== 1'(k % 5 != 4) ||
            w_ifstall !== 1'(k % 5 != 4)) begin
          err++;
          $display("FAIL contend[%0d]: i %b d %b stall %b",
                   k, w_igrant, w_dgrant, w_ifstall);
        end
      end
      if (k > 0) begin
        vec++;
        if (r_ivalid !== 1'((k - 1) % 5 == 4) ||
            r_dvalid !== 1'((k - 1) % 5 != 4)) begin
          err++;
          $display("FAIL contend_valid[%0d]: i %b d %b",
                   k, r_ivalid, r_dvalid);
        end
      end
    end
  endtask

  task automatic test_write_read();
    next_cycle();
    idle();
    w_dreq = 1; w_dwe = 1; w_daddr = 11'h10;
    w_ddin = 32'hDEAD_BEEF;
    @(negedge clk);
    vec++;
    if (w_dgrant !== 1'b1 || w_mwe !== 1'b1 ||
        w_maddr !== 11'h10 || w_mdin !== 32'hDEAD_BEEF) begin
      err++;
      $display("FAIL wr_mux: g %b we %b a %h d %h",
               w_dgrant, w_mwe, w_maddr, w_mdin);
    end
    golden[16] = 32'hDEAD_BEEF;
    next_cycle();
    w_dwe = 0;
    @(negedge clk);
    vec++;
    if (r_dvalid !== 1'b0 || w_dgrant !== 1'b1) begin
      err++;
      $display("FAIL wr_novalid: valid %b want 0", r_dvalid);
    end
    next_cycle();
    idle();
    @(negedge clk);
    vec++;
    if (r_dvalid !== 1'b1 || w_ddata !== 32'hDEAD_BEEF) begin
      err++;
      $display("FAIL raw: got %b/%h want 1/deadbeef",
               r_dvalid, w_ddata);
    end
  endtask

  task automatic test_loader();
    for (int c = 0; c < 9; c++) begin
      next_cycle();
      idle();
      if (c < 3) begin
        w_dreq = 1; w_daddr = 11'h40;
        w_lreq = 1; w_lwe = 1; w_laddr = 11'(c);
        w_ldin = 32'h5000_0000 + 32'(c);
        golden[c] = 32'h5000_0000 + 32'(c);
      end
      if (c < 5) w_ireq = 1;
      if (c >= 5 && c < 8) begin
        w_ireq = 1; w_iaddr = 11'(c - 5);
      end
      @(negedge clk);
      vec++;
      if (c < 3) begin
        if (r_mode !== ((c == 0) ? 2'd0 : 2'd1) ||
            {w_igrant, w_dgrant, w_lgrant} !== 3'b001 ||
            w_mwe !== 1'b1 || w_maddr !== 11'(c)) begin
          err++;
          $display("FAIL load[%0d]: mode %0d g %b we %b",
                   c, r_mode, {w_igrant, w_dgrant, w_lgrant}, w_mwe);
        end
      end else if (c < 5) begin
        if (r_mode !== ((c == 3) ? 2'd1 : 2'd2) ||
            {w_igrant, w_dgrant, w_lgrant} !== 3'b000 ||
            w_ifstall !== 1'b1) begin
          err++;
          $display("FAIL load_end[%0d]: mode %0d g %b",
                   c, r_mode, {w_igrant, w_dgrant, w_lgrant});
        end
      end else begin
        if (r_mode !== 2'd0 || w_igrant !== 1'(c < 8) ||
            r_ivalid !== 1'(c > 5) ||
            (c > 5 && w_idata !== golden[c-6])) begin
          err++;
          $display("FAIL load_run[%0d]: mode %0d g %b data %h",
                   c, r_mode, w_igrant, w_idata);
        end
      end
    end
  endtask

  task automatic test_pending_load();
    next_cycle();
    idle();
    w_ireq = 1; w_iaddr = 11'd5;
    @(negedge clk);
    vec++;
    if (w_igrant !== 1'b1) begin
      err++;
      $display("FAIL pend_n: got %b want 1", w_igrant);
    end
    next_cycle();
    idle();
    w_lreq = 1; w_laddr = 11'd7;
    @(negedge clk);
    vec++;
    if (w_lgrant !== 1'b1 || r_ivalid !== 1'b1 ||
        w_idata !== golden[5] || r_mode !== 2'd0) begin
      err++;
      $display("FAIL pend_n1: lg %b iv %b d %h want 1 1 %h",
               w_lgrant, r_ivalid, w_idata, golden[5]);
    end
    next_cycle();
    idle();
    @(negedge clk);
    vec++;
    if (r_mode !== 2'd1 || r_lvalid !== 1'b1 ||
        w_ldata !== golden[7] || w_lgrant !== 1'b0) begin
      err++;
      $display("FAIL pend_n2: mode %0d lv %b d %h want 1 1 %h",
               r_mode, r_lvalid, w_ldata, golden[7]);
    end
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      @(negedge clk);
      vec++;
      if (r_mode !== ((c == 0) ? 2'd2 : 2'd0)) begin
        err++;
        $display("FAIL pend_mode[%0d]: got %0d", c, r_mode);
      end
    end
  endtask

  task automatic test_reset_load();
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      idle();
      w_ireq = 1; w_dreq = 1;
    end
    next_cycle();
    idle();
    w_ireq = 1; w_lreq = 1; w_laddr = 11'd9;
    next_cycle();
    w_rst = 1;
    @(negedge clk);
    vec++;
    if (r_mode !== 2'd1 || dut.starve_q !== 3'd3 ||
        w_lgrant !== 1'b1 || r_lvalid !== 1'b1) begin
      err++;
      $display("FAIL rl_pre: mode %0d starve %0d lg %b lv %b",
               r_mode, dut.starve_q, w_lgrant, r_lvalid);
    end
    next_cycle();
    w_rst = 0;
    idle();
    @(negedge clk);
    vec++;
    if (r_mode !== 2'd0 || dut.starve_q !== 3'd0 ||
        {r_ivalid, r_dvalid, r_lvalid} !== 3'b000 ||
        w_ldata !== 32'd0) begin
      err++;
      $display("FAIL rl_post: mode %0d starve %0d v %b want 0 0 000",
               r_mode, dut.starve_q, {r_ivalid, r_dvalid, r_lvalid});
    end
  endtask

  task automatic test_random();
    int          g, order[$];
    logic        req[4];
    logic        we;
    logic [10:0] a;
    logic [31:0] din;
    w_rst = 1;
    idle();
    next_cycle();
    w_rst = 0;
    m_mode = 0; m_starve = 0; m_pend = 0; m_pdata = '0;
    for (int n = 0; n < 600; n++) begin
      w_ireq  = ($urandom_range(0, 3) != 0);
      w_iaddr = 11'($urandom_range(0, 31));
      w_dreq  = 1'($urandom_range(0, 1));
      w_dwe   = 1'($urandom_range(0, 1));
      w_daddr = 11'($urandom_range(0, 31));
      w_ddin  = $urandom;
      w_lreq  = (m_mode == 0) ? ($urandom_range(0, 9) == 0)
                              : ($urandom_range(0, 3) != 0);
      w_lwe   = 1'($urandom_range(0, 1));
      w_laddr = 11'($urandom_range(0, 31));
      w_ldin  = $urandom;
      w_rst   = ($urandom_range(0, 59) == 0);
      req[0] = 0; req[1] = w_ireq; req[2] = w_dreq; req[3] = w_lreq;
      // priority lists: 1 fetch, 2 data, 3 loader
      if (m_mode == 0)
        order = (m_starve == SMAX) ? '{3, 1, 2} : '{3, 2, 1};
      else if (m_mode == 1)
        order = '{3};
      else
        order = {};
      g = 0;
      foreach (order[k]) if (g == 0 && req[order[k]]) g = order[k];
      we  = (g == 2) ? w_dwe : (g == 3) ? w_lwe : 1'b0;
      a   = (g == 1) ? w_iaddr : (g == 2) ? w_daddr :
            (g == 3) ? w_laddr : 11'd0;
      din = (g == 2) ? w_ddin : (g == 3) ? w_ldin : 32'd0;
      @(negedge clk);
      vec++;
      if ({w_igrant, w_dgrant, w_lgrant} !==
          {1'(g == 1), 1'(g == 2), 1'(g == 3)} ||
          w_ifstall !== (w_ireq && g != 1) ||
          r_mode !== 2'(m_mode)) begin
        err++;
        $display("FAIL rnd_grant[%0d]: g %b want %0d mode %0d/%0d",
                 n, {w_igrant, w_dgrant, w_lgrant}, g, r_mode, m_mode);
      end
      vec++;
      if (w_maddr !== a || w_mwe !== we ||
          (g != 1 && w_mdin !== din)) begin
        err++;
        $display("FAIL rnd_mux[%0d]: a %h we %b d %h want %h %b %h",
                 n, w_maddr, w_mwe, w_mdin, a, we, din);
      end
      vec++;
      if ({r_ivalid, r_dvalid, r_lvalid} !==
          {1'(m_pend == 1), 1'(m_pend == 2), 1'(m_pend == 3)} ||
          w_idata !== ((m_pend == 1) ? m_pdata : 32'd0) ||
          w_ddata !== ((m_pend == 2) ? m_pdata : 32'd0) ||
          w_ldata !== ((m_pend == 3) ? m_pdata : 32'd0)) begin
        err++;
        $display("FAIL rnd_ret[%0d]: v %b i %h d %h l %h want %0d %h",
                 n, {r_ivalid, r_dvalid, r_lvalid},
                 w_idata, w_ddata, w_ldata, m_pend, m_pdata);
      end
      @(posedge clk);
      m_pend  = (g != 0 && !we) ? g : 0;
      m_pdata = golden[a];
      if (g != 0 && we) golden[a] = din;
      if (w_rst) begin
        m_mode = 0; m_starve = 0; m_pend = 0;
      end else begin
        if (m_mode == 0) begin
          m_starve = (w_ireq && g != 1)
                   ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
          m_mode = w_lreq ? 1 : 0;
        end else if (m_mode == 1) begin
          m_mode = w_lreq ? 1 : 2;
        end else begin
          m_mode = w_lreq ? 1 : 0;
        end
      end
      #1;
    end
    w_rst = 0;
    idle();
  endtask

  initial begin
    idle();
    w_rst = 1;
    test_reset();
    test_fetch_only();
    test_contention();
    test_write_read();
    test_loader();
    test_pending_load();
    test_reset_load();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/m_memarb.md
# m_memarb

Single-port memory arbiter and sequencer. It shares one `m_memory` instance (2048×32, synchronous read, 1-cycle latency) between three requesters: the instruction-fetch stage, the MEM-stage data port, and a program loader port (VIO/debug). It sits between the pipeline of `m_proc11` and the memory. It exposes per-requester grant signals so the pipeline can interlock on denial, and a loader mode that quiesces the pipeline while memory is rewritten.

## Interface
- `AW`, 11, word-address width
- `DW`, 32, data width
- `STARVE_MAX`, 4, consecutive fetch denials before fetch outranks data (1..7)

Ports:
- `w_clk`  in  1  clock; all state updates on posedge
- `w_rst`  in  1  reset, synchronous, active-high
- `w_ireq`  in  1  fetch request (read only)
- `w_iaddr`  in  AW  fetch word address
- `w_igrant`  out  1  fetch granted this cycle (combinational)
- `r_ivalid`  out  1  fetch data valid (registered)
- `w_idata`  out  DW  fetch read data; 0 when `r_ivalid`=0
- `w_dreq`, `w_dwe`  in  1  data request, data write-enable
- `w_daddr`  in  AW; `w_ddin`  in  DW  data address, write data
- `w_dgrant`  out  1; `r_dvalid`  out  1; `w_ddata`  out  DW  as fetch port, data side
- `w_lreq`, `w_lwe`  in  1; `w_laddr`  in  AW; `w_ldin`  in  DW  loader request
- `w_lgrant`  out  1; `r_lvalid`  out  1; `w_ldata`  out  DW  as fetch port, loader side
- `w_maddr`  out  AW; `w_mwe`  out  1; `w_mdin`  out  DW  to memory
- `w_mdout`  in  DW  memory registered read data
- `w_ifstall`  out  1  `w_ireq & !w_igrant`; used by the pipeline as an interlock term
- `r_mode`  out  2  FSM state: 0 RUN, 1 LOAD, 2 DRAIN

## Operation
- FSM states:
  - RUN: on `w_lreq`=1, go to LOAD. That cycle the loader is granted, and fetch and data are denied.
  - LOAD: only the loader can be granted. Fetch and data are denied regardless of `w_ireq`/`w_dreq`. When `w_lreq`=0, go to DRAIN.
  - DRAIN: exactly one cycle. No grants. Then go to RUN, or to LOAD if `w_lreq`=1 in DRAIN.
- RUN priority: data > fetch.
  - Exception: when `r_starve`==`STARVE_MAX`, fetch beats data and data is denied.
  - At most one grant per cycle.
- Starvation counter `r_starve` (3 bits, internal):
  - RUN and `w_ireq & !w_igrant`: increment, saturating at `STARVE_MAX`.
  - `w_igrant`=1 or `w_ireq`=0: reset to 0.
  - LOAD and DRAIN: hold.
- Memory mux:
  - The granted requester drives `w_maddr`/`w_mwe`/`w_mdin`. Fetch always drives `w_mwe`=0.
  - No grant: `w_maddr`=0, `w_mwe`=0, `w_mdin`=0.
- Read return:
  - Owner register `r_own` is set to the granted requester when the grant is a read (`we`=0), else to none.
  - Next cycle, exactly the owner's `r_*valid`=1 and its data output = `w_mdout`. All other data outputs are 0.
  - Write grants produce no valid.
- Address width: only bits [AW-1:0] are used. No wrap handling is needed; addresses index memory directly.

## Timing
- Grant latency 0: `w_*grant` is combinational from requests, `r_starve` and `r_mode` in the same cycle.
- Memory samples `w_maddr`/`w_mwe`/`w_mdin` at the posedge ending the grant cycle.
- Read data latency 1: `r_*valid`/`w_*data` are valid the cycle after the grant.
- Back-to-back grants are allowed every cycle.
- A read granted in the cycle before LOAD entry still returns its valid in the first LOAD cycle.
- Write then read of the same address in consecutive cycles returns the new value.
- A read and write on the same address can never share a cycle: only one grant per cycle.
- Reset (`w_rst`=1 at posedge) resets the following:
  - `r_mode`=RUN, `r_starve`=0, `r_own`=none.
  - All `r_*valid`=0, so all data outputs are 0.
  - Grants during a reset cycle are still combinationally asserted, but any pending return is discarded.
  - Reset mid-LOAD returns to RUN immediately, with no DRAIN.
- Simultaneous `w_lreq` with `w_dreq`/`w_ireq` in RUN: the loader wins and LOAD is entered.

## Test plan
- **Fetch only:** `w_ireq`=1, addr 0,1,2 on consecutive cycles -> `w_igrant`=1 every cycle; `r_ivalid`=1 with `w_idata`=mem[0],mem[1],mem[2] one cycle later each.
- **Contention:** `w_ireq`=`w_dreq`=1 continuously, data reads, `STARVE_MAX`=4 -> data granted 4 cycles, fetch in cycle 5, pattern repeats; `w_ifstall`=1 exactly on denied cycles.
- **Data write then read:** data write addr 0x10 value 0xDEADBEEF, next cycle data read addr 0x10 -> `r_dvalid`=1 with 0xDEADBEEF; no valid after the write cycle.
- **Loader:** `w_lreq`=1 for 3 writes to addr 0..2 while `w_ireq`=`w_dreq`=1 -> `r_mode`=1; `w_igrant`=`w_dgrant`=0 throughout LOAD; after `w_lreq` drops, `r_mode`=2 for one cycle with no grant, then RUN with fetch reading the new values.
- **Reset:** assert `w_rst` mid-LOAD with `r_starve`=3 -> next cycle `r_mode`=0, `r_starve`=0, all valids 0.
- **Pending read at LOAD entry:** fetch read granted at cycle N, `w_lreq` rises at N+1 -> `r_ivalid`=1 at N+1, `w_lgrant`=1 at N+1.
